pipelined_comparator: RTL and testbench

- Parametrised, pipelined magnitude comparator. Reports equal / less-than / greater-than for two WIDTH-bit operands, in unsigned or signed mode.
- Processes CHUNK bits per stage, MSB chunk first, so wide compares close timing on the Basys3 fabric.
- Streams operand pairs through a valid/ready handshake with full backpressure.
- Keeps a saturating count of equal results. Sits between operand producers (switch/UART front-ends) and display/control logic.

---
 rtl/pipelined_comparator.sv | 162 ++++++++++++++++
 tb/tb_pipelined_comparator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_comparator.sv
// rtl/pipelined_comparator.sv - pipelined signed/unsigned magnitude comparator with equal-result counter
//
// Compares two WIDTH-bit operands CHUNK bits per stage, most significant chunk
// first, over STAGES = ceil(WIDTH/CHUNK) pipeline stages.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair + mode present
//   in_ready     block can accept this cycle (= !stall)
//   A, B         operands
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   out_valid    result present on eq/lt/gt
//   out_ready    consumer takes result this cycle
//   eq, lt, gt   compare result, held while out_valid=0
//   cnt_clr      synchronous clear of eq_count
//   eq_count     saturating count of delivered eq=1 results
module pipelined_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] eq_count
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = STAGES * CHUNK;
  localparam int LAST   = STAGES - 1;

  logic              stall;
  logic [PW-1:0]     a_ext, b_ext;
  logic [CHUNK-1:0]  ca, cb;

  logic [STAGES-1:0] valid_q, dec_q, lt_q, gt_q;
  logic [STAGES-1:0] valid_d, dec_d, lt_d, gt_d;
  logic [PW-1:0]     a_q [STAGES];
  logic [PW-1:0]     b_q [STAGES];
  logic [PW-1:0]     a_d [STAGES];
  logic [PW-1:0]     b_d [STAGES];

  // Inputs seen by each stage: stage 0 takes the prepared operands, later
  // stages take the previous stage's registers.
  logic [STAGES-1:0] v_src, dec_src, lt_src, gt_src;
  logic [PW-1:0]     a_src [STAGES];
  logic [PW-1:0]     b_src [STAGES];

  logic [CNT_W-1:0]  cnt_q;

  assign stall     = valid_q[LAST] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[LAST];
  assign eq        = ~dec_q[LAST];
  assign lt        = lt_q[LAST];
  assign gt        = gt_q[LAST];
  assign eq_count  = cnt_q;

  always_comb begin
    // Flipping the sign bit maps two's-complement order onto unsigned order;
    // padding zeros on the MSB side never influence the result.
    a_ext              = '0;
    b_ext              = '0;
    a_ext[WIDTH-1:0]   = A;
    b_ext[WIDTH-1:0]   = B;
    a_ext[WIDTH-1]     = A[WIDTH-1] ^ signed_mode;
    b_ext[WIDTH-1]     = B[WIDTH-1] ^ signed_mode;

    v_src   = '0;
    dec_src = '0;
    lt_src  = '0;
    gt_src  = '0;
    a_src[0] = a_ext;
    b_src[0] = b_ext;
    v_src[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      a_src[s]   = a_q[s-1];
      b_src[s]   = b_q[s-1];
      v_src[s]   = valid_q[s-1];
      dec_src[s] = dec_q[s-1];
      lt_src[s]  = lt_q[s-1];
      gt_src[s]  = gt_q[s-1];
    end

    ca = '0;
    cb = '0;
    for (int s = 0; s < STAGES; s++) begin
      valid_d[s] = v_src[s];
      a_d[s]     = a_q[s];
      b_d[s]     = b_q[s];
      dec_d[s]   = dec_q[s];
      lt_d[s]    = lt_q[s];
      gt_d[s]    = gt_q[s];
      // Data only moves with a valid token so the last stage keeps showing
      // its previous result across bubbles.
      if (v_src[s]) begin
        ca     = a_src[s][PW-1-s*CHUNK -: CHUNK];
        cb     = b_src[s][PW-1-s*CHUNK -: CHUNK];
        a_d[s] = a_src[s];
        b_d[s] = b_src[s];
        if (dec_src[s]) begin
          dec_d[s] = 1'b1;
          lt_d[s]  = lt_src[s];
          gt_d[s]  = gt_src[s];
        end else if (ca != cb) begin
          dec_d[s] = 1'b1;
          lt_d[s]  = (ca < cb);
          gt_d[s]  = ~(ca < cb);
        end else begin
          dec_d[s] = 1'b0;
          lt_d[s]  = 1'b0;
          gt_d[s]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      // decided=1 with lt=gt=0 makes eq/lt/gt all read 0 out of reset.
      dec_q   <= '1;
      lt_q    <= '0;
      gt_q    <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
    end else if (!stall) begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && eq && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_comparator.sv
// tb/tb_pipelined_comparator.sv - self-checking bench for pipelined_comparator
module tb_pipelined_comparator;

  typedef struct {
    logic [2:0] r;
    int         acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, out_ready, sm, cnt_clr;
  logic [15:0] a_in [2];
  logic [15:0] b_in [2];
  logic [1:0]  in_ready, out_valid, eq, lt, gt;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  int          n_cmp, n_err;
  int          exp_cnt [2];
  logic [15:0] sa [$];
  logic [15:0] sb [$];
  logic        ss [$];

  always #5 clk = ~clk;

  pipelined_comparator #(.WIDTH(16), .CHUNK(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a_in[0]), .B(b_in[0]), .signed_mode(sm[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .eq(eq[0]), .lt(lt[0]), .gt(gt[0]),
    .cnt_clr(cnt_clr[0]), .eq_count(cnt0)
  );

  pipelined_comparator #(.WIDTH(10), .CHUNK(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a_in[1][9:0]), .B(b_in[1][9:0]), .signed_mode(sm[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .eq(eq[1]), .lt(lt[1]), .gt(gt[1]),
    .cnt_clr(cnt_clr[1]), .eq_count(cnt1)
  );

  // Reference: compare as mathematical integers; returns {eq,lt,gt}.
  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                         input logic s, input int w);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (s) begin
      if (a[w-1]) va = va - (longint'(1) << w);
      if (b[w-1]) vb = vb - (longint'(1) << w);
    end
    if (va == vb) return 3'b100;
    if (va < vb)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] mask_w(input int d, input logic [15:0] v);
    return (d == 0) ? v : (v & 16'h03FF);
  endfunction

  task automatic push_random(input int d, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = mask_w(d, 16'($urandom));
      sa.push_back(a);
      sb.push_back(($urandom_range(0, 3) == 0) ? a : mask_w(d, 16'($urandom)));
      ss.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Streams the queued pairs into DUT d and checks every delivered result.
  task automatic run_stream(input int d, input string name, input bit exact,
                            input int stall_len, input int clr_idx);
    exp_t        q [$];
    exp_t        e;
    int          n, idx, got, cyc, first_ov, stg, w, cmax;
    logic [3:0]  saved;
    bit          prev_stall, stl;
    logic [7:0]  cv;
    n = sa.size(); idx = 0; got = 0; cyc = 0; first_ov = -1; prev_stall = 0; saved = '0;
    stg = (d == 0) ? 4 : 3;
    w = (d == 0) ? 16 : 10;
    cmax = (d == 0) ? 255 : 3;
    while (got < n && cyc < 400) begin
      if (idx < n) begin
        in_valid[d] = 1'b1; a_in[d] = sa[idx]; b_in[d] = sb[idx]; sm[d] = ss[idx];
      end else begin
        in_valid[d] = 1'b0; a_in[d] = 16'($urandom); b_in[d] = 16'($urandom);
      end
      if (first_ov < 0 && out_valid[d]) first_ov = cyc;
      out_ready[d] = !(first_ov >= 0 && cyc < first_ov + stall_len);
      cnt_clr[d] = (got == clr_idx) && out_valid[d];
      @(negedge clk);
      cv = (d == 0) ? cnt0 : {6'b0, cnt1};
      stl = out_valid[d] && !out_ready[d];
      n_cmp++;
      if (in_ready[d] !== !stl) begin
        n_err++; $display("FAIL %s in_ready: got %b want %b", name, in_ready[d], !stl);
      end
      n_cmp++;
      if (cv !== 8'(exp_cnt[d])) begin
        n_err++; $display("FAIL %s eq_count: got %0d want %0d", name, cv, exp_cnt[d]);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid[d], eq[d], lt[d], gt[d]} !== saved) begin
          n_err++; $display("FAIL %s hold_during_stall: got %b want %b", name,
                            {out_valid[d], eq[d], lt[d], gt[d]}, saved);
        end
      end
      if (out_valid[d]) begin
        n_cmp++;
        if (!$onehot({eq[d], lt[d], gt[d]})) begin
          n_err++; $display("FAIL %s onehot: got %b want one bit set", name, {eq[d], lt[d], gt[d]});
        end
      end
      prev_stall = stl;
      saved = {out_valid[d], eq[d], lt[d], gt[d]};
      if (out_valid[d] && out_ready[d]) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL %s unexpected_output: got result %b want none", name, {eq[d], lt[d], gt[d]});
        end else begin
          e = q.pop_front();
          if ({eq[d], lt[d], gt[d]} !== e.r) begin
            n_err++; $display("FAIL %s result #%0d: got %b want %b", name, got, {eq[d], lt[d], gt[d]}, e.r);
          end
          if (exact) begin
            n_cmp++;
            if (cyc != e.acc + stg) begin
              n_err++; $display("FAIL %s latency #%0d: got %0d want %0d", name, got, cyc - e.acc, stg);
            end
          end
          if (e.r[2] && exp_cnt[d] < cmax) exp_cnt[d]++;
        end
        got++;
      end
      if (cnt_clr[d]) exp_cnt[d] = 0;
      if (in_valid[d] && in_ready[d]) begin
        e.r = ref_cmp(sa[idx], sb[idx], ss[idx], w);
        e.acc = cyc;
        q.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1; cnt_clr[d] = 1'b0;
    n_cmp++;
    if (got != n || q.size() != 0) begin
      n_err++; $display("FAIL %s delivered: got %0d want %0d (pending %0d)", name, got, n, q.size());
    end
    n_cmp++;
    cv = (d == 0) ? cnt0 : {6'b0, cnt1};
    if (cv !== 8'(exp_cnt[d])) begin
      n_err++; $display("FAIL %s final_eq_count: got %0d want %0d", name, cv, exp_cnt[d]);
    end
    for (int i = 0; i < stg + 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[d] !== 1'b0) begin
        n_err++; $display("FAIL %s extra_output: got out_valid %b want 0", name, out_valid[d]);
      end
      @(posedge clk); #1;
    end
    sa.delete(); sb.delete(); ss.delete();
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({out_valid[d], eq[d], lt[d], gt[d]} !== 4'b0000) begin
        n_err++; $display("FAIL reset outputs[%0d]: got %b want 0000", d, {out_valid[d], eq[d], lt[d], gt[d]});
      end
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
        n_err++; $display("FAIL reset in_ready[%0d]: got %b want 1", d, in_ready[d]);
      end
    end
    n_cmp++;
    if (cnt0 !== 8'd0 || cnt1 !== 2'd0) begin
      n_err++; $display("FAIL reset eq_count: got %0d/%0d want 0/0", cnt0, cnt1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    sa = '{16'h1234, 16'h1234, 16'h1234};
    sb = '{16'h1234, 16'h1235, 16'h1233};
    ss = '{1'b0, 1'b0, 1'b0};
    run_stream(0, "unsigned", 1'b1, 0, -1);
  endtask

  task automatic test_signed;
    sa = '{16'hFFFF, 16'hFFFF, 16'h8000};
    sb = '{16'h0001, 16'h0001, 16'h7FFF};
    ss = '{1'b1, 1'b0, 1'b1};
    push_random(0, 8);
    run_stream(0, "signed", 1'b1, 0, -1);
  endtask

  task automatic test_back_to_back;
    push_random(0, 24);
    run_stream(0, "back_to_back", 1'b1, 0, -1);
  endtask

  task automatic test_backpressure;
    push_random(0, 6);
    run_stream(0, "backpressure", 1'b0, 3, -1);
  endtask

  task automatic test_counter;
    logic [15:0] a;
    a = mask_w(1, 16'($urandom));
    for (int i = 0; i < 6; i++) begin
      sa.push_back(a); sb.push_back(a); ss.push_back(1'($urandom_range(0, 1)));
    end
    run_stream(1, "counter", 1'b1, 0, 5);
  endtask

  task automatic test_narrow;
    sa = '{16'h03FF, 16'h0200};
    sb = '{16'h03FE, 16'h0000};
    ss = '{1'b0, 1'b1};
    push_random(1, 8);
    run_stream(1, "narrow", 1'b1, 0, -1);
  endtask

  task automatic test_midflight_reset;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1; a_in[0] = 16'($urandom); b_in[0] = 16'($urandom); sm[0] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    n_cmp++;
    if (out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL midflight pre_reset_out_valid: got %b want 1", out_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid[0], eq[0], lt[0], gt[0]} !== 4'b0000) begin
      n_err++; $display("FAIL midflight async_clear: got %b want 0000", {out_valid[0], eq[0], lt[0], gt[0]});
    end
    n_cmp++;
    if (cnt0 !== 8'd0 || cnt1 !== 2'd0) begin
      n_err++; $display("FAIL midflight eq_count: got %0d/%0d want 0/0", cnt0, cnt1);
    end
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL midflight in_ready: got %b want 1", in_ready[0]);
    end
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[0] !== 1'b0) begin
        n_err++; $display("FAIL midflight stale_output: got out_valid %b want 0", out_valid[0]);
      end
      @(posedge clk); #1;
    end
    push_random(0, 1);
    run_stream(0, "post_reset", 1'b1, 0, -1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    in_valid = '0; out_ready = '0; sm = '0; cnt_clr = '0;
    a_in[0] = '0; a_in[1] = '0; b_in[0] = '0; b_in[1] = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    test_reset;
    test_unsigned;
    test_signed;
    test_back_to_back;
    test_backpressure;
    test_counter;
    test_narrow;
    test_midflight_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
